kamus_csr_file: RTL and testbench
=================================

// Module: kamus_csr_file
// PURPOSE
//  Machine-mode CSR register file: the write/update side of the CSR path. EX issues CSRRW/CSRRS/CSRRC reads.
//  Returns old CSR value; commits read-modify-write on the next clock edge.
//  Owns 64-bit cycle/instret/timecmp counters, trap entry (mepc/mcause/mbadaddr/mstatus), MRET, interrupt pending.
//  Sits beside EX/MEM; feeds trap vector and EPC to the fetch redirect logic.
// PARAMETERS
//  MTVEC_RESET  32'h0000_0100  reset value of mtvec (bits[1:0] forced 0)
//  HART_ID      0              value returned by MHARTID
// PORTS
//  clk_i          in   1   core clock
//  rst_ni         in   1   asynchronous active-low reset
//  csr_op_i       in   2   csr_op_e: CSR_NONE/CSR_RW/CSR_RS/CSR_RC; one access per cycle
//  csr_addr_i     in   12  csr_e address (funct12)
//  csr_wdata_i    in   32  rs1 value or zimm
//  csr_rdata_o    out  32  pre-write CSR value, combinational from csr_op_i/csr_addr_i
//  csr_illegal_o  out  1   unknown address, or write attempt to read-only CSR
//  retire_i       in   1   one instruction retired this cycle
//  trap_i         in   1   take synchronous exception or interrupt this cycle
//  trap_cause_i   in   32  mcause value (bit31 = interrupt)
//  trap_pc_i      in   32  pc of trapping instruction
//  trap_tval_i    in   32  faulting address/instr → mbadaddr
//  mret_i         in   1   MRET executing
//  irq_ext_i      in   1   level external interrupt → mip.meip
//  irq_sw_i       in   1   level software interrupt → mip.msip
//  trap_vector_o  out  32  {mtvec[31:2],2'b0}
//  epc_o          out  32  {mepc[31:2],2'b0}
//  irq_pending_o  out  1   mstatus.mie & |(mip & mie)
// BEHAVIOUR
//  Reset (async, rst_ni=0): cycles/instret=0, timecmp=64'hFFFF_FFFF_FFFF_FFFF, mtvec=MTVEC_RESET,
//   mepc/mcause/mbadaddr/mscratch/dscratch=0, mstatus.mie=0, mpie=0, mie.*=0. All outputs derive -> 0 except trap_vector_o.
//  Read: csr_rdata_o = current value; mstatus reads {19'b0,2'b11,3'b0,mpie,3'b0,mie,3'b0}; MISA 32'h4000_0100;
//   MVENDORID/MARCHID/MIMPID/MEDELEG/MIDELEG = 0; MHARTID = HART_ID; undefined addr -> 0 + csr_illegal_o.
//  Write value: RW: wdata; RS: old|wdata; RC: old&~wdata. RS/RC with wdata==0 perform no write (no side effects).
//  Latency: write visible on csr_rdata_o the cycle after the access. Writes to CYCLE*/TIME*/MISA/MVENDORID/
//   MARCHID/MIMPID/MHARTID (read-only space addr[11:10]==2'b11) -> csr_illegal_o=1, no state change.
//  WARL: mtvec/mepc bits[1:0] stored 0; mcause stores only bits 31 and 3:0.
//  Counters: cycles += 1 every cycle; instret += retire_i. A CSR write to MCYCLE(H)/MINSTRET(H) replaces that half
//   that cycle and suppresses that cycle's increment. Low-word increment carries into high word at 32'hFFFF_FFFF.
//  Timer: mip.mtip = (cycles >= timecmp), unsigned 64-bit compare, recomputed each cycle; writes to MTIMECMP(H)
//   update halves independently.
//  Trap (trap_i=1): mepc<=trap_pc_i, mcause<=trap_cause_i, mbadaddr<=trap_tval_i, mpie<=mie, mie<=0.
//  MRET (mret_i=1, trap_i=0): mie<=mpie, mpie<=1.
//  Priority same cycle: trap_i > mret_i > CSR write; lower-priority updates to overlapping state are dropped,
//   and a concurrent CSR write is fully dropped when trap_i=1. retire_i still counts.
//  Reset asserted mid-operation aborts any pending update; no partial write survives.
// STRUCTURE
//  kamus package gains: csr_op_e, mstatus_t {mie,mpie}, mip_t/mie_t {meip,mtip,msip}, CSR_RO_MASK constant;
//   csr_e addresses remain in the package.
//  Sub-module kamus_counter64: 64-bit counter, inc_i, wr_lo_i/wr_hi_i, wdata_i, value_o; instantiated for cycles
//   and instret.
//  Write-data mux + priority resolver is combinational; one always_ff per register group.
// TESTING
//  Reset release -> read MTVEC = 32'h100, MSTATUS = 32'h1800, MCYCLE advances 1/cycle from 0.
//  CSRRW MSCRATCH 32'hDEAD_BEEF, then CSRRS wdata 32'h0000_00F0 -> rdata DEADBEEF then DEADBEFF.
//  Write MCYCLE=32'hFFFF_FFFE -> MCYCLEH increments to 1 two cycles later; same-cycle increment suppressed.
//  Set MIE.mtie=1, mstatus.mie=1, timecmp=cycles+5 -> irq_pending_o rises exactly when cycles==timecmp.
//  trap_i cause 2, pc 32'h1003 with concurrent CSRRW MSCRATCH -> epc_o=32'h1000, mie=0, mpie=1, MSCRATCH unchanged;
//   MRET -> mie=1.
//  CSRRW CYCLE or addr 12'h7FF -> csr_illegal_o=1, no state change; CSRRS CYCLE wdata 0 -> legal read.

Source files
------------

// File: rtl/kamus_csr_file_pkg.sv
// kamus_csr_file_pkg
//   Shared types and constants for the machine-mode CSR file: access opcodes,
//   CSR address map, mstatus / interrupt bit groups and WARL masks.
package kamus_csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [11:0] {
        CSR_MSTATUS   = 12'h300,
        CSR_MEDELEG   = 12'h302,
        CSR_MIDELEG   = 12'h303,
        CSR_MIE       = 12'h304,
        CSR_MTVEC     = 12'h305,
        CSR_MSCRATCH  = 12'h340,
        CSR_MEPC      = 12'h341,
        CSR_MCAUSE    = 12'h342,
        CSR_MBADADDR  = 12'h343,
        CSR_MIP       = 12'h344,
        CSR_DSCRATCH  = 12'h7B2,
        CSR_MTIMECMP  = 12'h7C0,
        CSR_MTIMECMPH = 12'h7C1,
        CSR_MCYCLE    = 12'hB00,
        CSR_MINSTRET  = 12'hB02,
        CSR_MCYCLEH   = 12'hB80,
        CSR_MINSTRETH = 12'hB82,
        CSR_CYCLE     = 12'hC00,
        CSR_TIME      = 12'hC01,
        CSR_INSTRET   = 12'hC02,
        CSR_CYCLEH    = 12'hC80,
        CSR_TIMEH     = 12'hC81,
        CSR_INSTRETH  = 12'hC82,
        CSR_MISA      = 12'hF10,
        CSR_MVENDORID = 12'hF11,
        CSR_MARCHID   = 12'hF12,
        CSR_MIMPID    = 12'hF13,
        CSR_MHARTID   = 12'hF14
    } csr_e;

    typedef struct packed {
        logic mpie;
        logic mie;
    } mstatus_t;

    typedef struct packed {
        logic meip;
        logic mtip;
        logic msip;
    } mip_t;

    typedef struct packed {
        logic meie;
        logic mtie;
        logic msie;
    } mie_t;

    // addr[11:10] == 2'b11 marks the read-only CSR space
    localparam logic [11:0] CSR_RO_MASK = 12'hC00;

    localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;
    localparam logic [31:0] ALIGN4_MASK  = 32'hFFFF_FFFC;
    localparam logic [31:0] MCAUSE_MASK  = 32'h8000_000F;

    function automatic logic csr_is_ro(input logic [11:0] addr);
        return (addr & CSR_RO_MASK) == CSR_RO_MASK;
    endfunction

    // MPP is hardwired to machine mode (bits 12:11)
    function automatic logic [31:0] mstatus_word(input mstatus_t s);
        return {19'b0, 2'b11, 3'b0, s.mpie, 3'b0, s.mie, 3'b0};
    endfunction

    function automatic logic [31:0] irq_word(input logic e, input logic t, input logic s);
        return {20'b0, e, 3'b0, t, 3'b0, s, 3'b0};
    endfunction

endpackage

// File: rtl/kamus_csr_file_if.sv
// kamus_csr_file_if
//   CSR access bus between EX (master) and the CSR file (slave).
//   op/addr/wdata : access request, one per cycle
//   rdata/illegal : combinational pre-write value and access fault
interface kamus_csr_file_if;
    import kamus_csr_file_pkg::*;

    csr_op_e     op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        illegal;

    modport master (
        output op, addr, wdata,
        input  rdata, illegal
    );

    modport slave (
        input  op, addr, wdata,
        output rdata, illegal
    );

endinterface

// File: rtl/kamus_counter64.sv
// kamus_counter64
//   64-bit free-running counter with independent 32-bit half writes.
//   inc_i   : increment by one this cycle
//   wr_lo_i : replace bits 31:0 with wdata_i (increment suppressed)
//   wr_hi_i : replace bits 63:32 with wdata_i (increment suppressed)
//   value_o : current count
module kamus_counter64 (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i) begin
            cnt_d[31:0] = wdata_i;
        end else if (wr_hi_i) begin
            cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/kamus_csr_file.sv
// kamus_csr_file
//   Machine-mode CSR register file: CSRRW/RS/RC read-modify-write, 64-bit
//   cycle/instret/timecmp, trap entry, MRET and interrupt pending.
//   clk_i, rst_ni        : clock, async active-low reset
//   csr_bus              : CSR access bus (slave side)
//   retire_i             : instruction retired this cycle
//   trap_i/_cause/_pc/_tval : trap entry request and its state
//   mret_i               : MRET executing
//   irq_ext_i, irq_sw_i  : level interrupt inputs
//   trap_vector_o, epc_o : redirect targets for fetch
//   irq_pending_o        : enabled interrupt pending
module kamus_csr_file
    import kamus_csr_file_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    kamus_csr_file_if.slave        csr_bus,
    input  logic                   retire_i,
    input  logic                   trap_i,
    input  logic [31:0]            trap_cause_i,
    input  logic [31:0]            trap_pc_i,
    input  logic [31:0]            trap_tval_i,
    input  logic                   mret_i,
    input  logic                   irq_ext_i,
    input  logic                   irq_sw_i,
    output logic [31:0]            trap_vector_o,
    output logic [31:0]            epc_o,
    output logic                   irq_pending_o
);

    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] dscratch_q, dscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mbadaddr_q, mbadaddr_d;
    mstatus_t    mstatus_q, mstatus_d;
    mie_t        mie_q, mie_d;
    logic [63:0] timecmp_q, timecmp_d;

    logic [63:0] cycles, instret;
    mip_t        mip;

    logic [31:0] rd_val;
    logic [31:0] wr_val;
    logic        known;
    logic        access;
    logic        wr_attempt;
    logic        illegal;
    logic        wr_en;

    assign mip.meip = irq_ext_i;
    assign mip.msip = irq_sw_i;
    assign mip.mtip = (cycles >= timecmp_q);

    // ---------------- read decode ----------------
    always_comb begin
        rd_val = '0;
        known  = 1'b1;
        case (csr_bus.addr)
            CSR_MSTATUS:                         rd_val = mstatus_word(mstatus_q);
            CSR_MISA:                            rd_val = MISA_VALUE;
            CSR_MVENDORID, CSR_MARCHID,
            CSR_MIMPID, CSR_MEDELEG,
            CSR_MIDELEG:                         rd_val = '0;
            CSR_MHARTID:                         rd_val = HART_ID;
            CSR_MIE:                             rd_val = irq_word(mie_q.meie, mie_q.mtie, mie_q.msie);
            CSR_MIP:                             rd_val = irq_word(mip.meip, mip.mtip, mip.msip);
            CSR_MTVEC:                           rd_val = mtvec_q;
            CSR_MSCRATCH:                        rd_val = mscratch_q;
            CSR_DSCRATCH:                        rd_val = dscratch_q;
            CSR_MEPC:                            rd_val = mepc_q;
            CSR_MCAUSE:                          rd_val = mcause_q;
            CSR_MBADADDR:                        rd_val = mbadaddr_q;
            CSR_MTIMECMP:                        rd_val = timecmp_q[31:0];
            CSR_MTIMECMPH:                       rd_val = timecmp_q[63:32];
            CSR_MCYCLE, CSR_CYCLE, CSR_TIME:     rd_val = cycles[31:0];
            CSR_MCYCLEH, CSR_CYCLEH, CSR_TIMEH:  rd_val = cycles[63:32];
            CSR_MINSTRET, CSR_INSTRET:           rd_val = instret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH:         rd_val = instret[63:32];
            default:                             known  = 1'b0;
        endcase
    end

    // ---------------- write data and legality ----------------
    always_comb begin
        case (csr_bus.op)
            CSR_RW:  wr_val = csr_bus.wdata;
            CSR_RS:  wr_val = rd_val | csr_bus.wdata;
            CSR_RC:  wr_val = rd_val & ~csr_bus.wdata;
            default: wr_val = rd_val;
        endcase
    end

    assign access     = (csr_bus.op != CSR_NONE);
    // RS/RC with a zero mask are pure reads and never fault on read-only CSRs
    assign wr_attempt = access && ((csr_bus.op == CSR_RW) || (csr_bus.wdata != '0));
    assign illegal    = access && (!known || (wr_attempt && csr_is_ro(csr_bus.addr)));
    assign wr_en      = wr_attempt && !illegal && !trap_i;

    assign csr_bus.rdata   = access ? rd_val : '0;
    assign csr_bus.illegal = illegal;

    // ---------------- next state ----------------
    always_comb begin
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        dscratch_d = dscratch_q;
        timecmp_d  = timecmp_q;
        mie_d      = mie_q;
        if (wr_en) begin
            case (csr_bus.addr)
                CSR_MTVEC:     mtvec_d    = wr_val & ALIGN4_MASK;
                CSR_MSCRATCH:  mscratch_d = wr_val;
                CSR_DSCRATCH:  dscratch_d = wr_val;
                CSR_MTIMECMP:  timecmp_d[31:0]  = wr_val;
                CSR_MTIMECMPH: timecmp_d[63:32] = wr_val;
                CSR_MIE:       mie_d = '{meie: wr_val[11], mtie: wr_val[7], msie: wr_val[3]};
                default: ;
            endcase
        end
    end

    always_comb begin
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mbadaddr_d = mbadaddr_q;
        if (trap_i) begin
            mepc_d     = trap_pc_i & ALIGN4_MASK;
            mcause_d   = trap_cause_i & MCAUSE_MASK;
            mbadaddr_d = trap_tval_i;
        end else if (wr_en) begin
            case (csr_bus.addr)
                CSR_MEPC:     mepc_d     = wr_val & ALIGN4_MASK;
                CSR_MCAUSE:   mcause_d   = wr_val & MCAUSE_MASK;
                CSR_MBADADDR: mbadaddr_d = wr_val;
                default: ;
            endcase
        end
    end

    // trap > MRET > CSR write for the shared mie/mpie bits
    always_comb begin
        mstatus_d = mstatus_q;
        if (trap_i) begin
            mstatus_d.mpie = mstatus_q.mie;
            mstatus_d.mie  = 1'b0;
        end else if (mret_i) begin
            mstatus_d.mie  = mstatus_q.mpie;
            mstatus_d.mpie = 1'b1;
        end else if (wr_en && (csr_bus.addr == CSR_MSTATUS)) begin
            mstatus_d.mie  = wr_val[3];
            mstatus_d.mpie = wr_val[7];
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtvec_q    <= MTVEC_RESET & ALIGN4_MASK;
            mscratch_q <= '0;
            dscratch_q <= '0;
        end else begin
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            dscratch_q <= dscratch_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mepc_q     <= '0;
            mcause_q   <= '0;
            mbadaddr_q <= '0;
        end else begin
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mbadaddr_q <= mbadaddr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mstatus_q <= '0;
            mie_q     <= '0;
        end else begin
            mstatus_q <= mstatus_d;
            mie_q     <= mie_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timecmp_q <= '1;
        end else begin
            timecmp_q <= timecmp_d;
        end
    end

    // ---------------- counters ----------------
    kamus_counter64 u_cycles (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (1'b1),
        .wr_lo_i (wr_en && (csr_bus.addr == CSR_MCYCLE)),
        .wr_hi_i (wr_en && (csr_bus.addr == CSR_MCYCLEH)),
        .wdata_i (wr_val),
        .value_o (cycles)
    );

    kamus_counter64 u_instret (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (retire_i),
        .wr_lo_i (wr_en && (csr_bus.addr == CSR_MINSTRET)),
        .wr_hi_i (wr_en && (csr_bus.addr == CSR_MINSTRETH)),
        .wdata_i (wr_val),
        .value_o (instret)
    );

    // ---------------- outputs ----------------
    assign trap_vector_o = mtvec_q & ALIGN4_MASK;
    assign epc_o         = mepc_q & ALIGN4_MASK;
    assign irq_pending_o = mstatus_q.mie & ((mip.meip & mie_q.meie) |
                                            (mip.mtip & mie_q.mtie) |
                                            (mip.msip & mie_q.msie));

endmodule

// File: tb/tb_kamus_csr_file.sv
module tb_kamus_csr_file;
    import kamus_csr_file_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        retire, trap, mret, irq_ext, irq_sw;
    logic [31:0] trap_cause, trap_pc, trap_tval;
    logic [31:0] trap_vector, epc;
    logic        irq_pending;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    kamus_csr_file_if bus ();

    kamus_csr_file #(
        .MTVEC_RESET (32'h0000_0100),
        .HART_ID     (32'd0)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .csr_bus       (bus),
        .retire_i      (retire),
        .trap_i        (trap),
        .trap_cause_i  (trap_cause),
        .trap_pc_i     (trap_pc),
        .trap_tval_i   (trap_tval),
        .mret_i        (mret),
        .irq_ext_i     (irq_ext),
        .irq_sw_i      (irq_sw),
        .trap_vector_o (trap_vector),
        .epc_o         (epc),
        .irq_pending_o (irq_pending)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic acc(input csr_op_e op, input logic [11:0] addr, input logic [31:0] wdata);
        bus.op    = op;
        bus.addr  = addr;
        bus.wdata = wdata;
        #1;
    endtask

    task automatic test_reset();
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata_idle: got %h exp %h", bus.rdata, 32'h0); end
        vectors++; if (bus.illegal !== 1'b0) begin miscompares++; $display("FAIL reset_illegal: got %b exp 0", bus.illegal); end
        vectors++; if (trap_vector !== 32'h100) begin miscompares++; $display("FAIL reset_trap_vector: got %h exp %h", trap_vector, 32'h100); end
        vectors++; if (epc !== 32'h0) begin miscompares++; $display("FAIL reset_epc: got %h exp 0", epc); end
        vectors++; if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b exp 0", irq_pending); end
        acc(CSR_RS, CSR_MTVEC, 32'h0);
        vectors++; if (bus.rdata !== 32'h100) begin miscompares++; $display("FAIL reset_mtvec: got %h exp %h", bus.rdata, 32'h100); end
        acc(CSR_RS, CSR_MSTATUS, 32'h0);
        vectors++; if (bus.rdata !== 32'h1800) begin miscompares++; $display("FAIL reset_mstatus: got %h exp %h", bus.rdata, 32'h1800); end
        rst_n = 1'b1;
        acc(CSR_RS, CSR_MCYCLE, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mcycle_start: got %h exp 0", bus.rdata); end
        for (int unsigned i = 1; i <= 3; i++) begin
            cyc();
            vectors++; if (bus.rdata !== i) begin miscompares++; $display("FAIL mcycle_step: got %h exp %h", bus.rdata, i); end
        end
    endtask

    task automatic test_rmw();
        acc(CSR_RW, CSR_MSCRATCH, 32'hDEAD_BEEF);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL rw_old: got %h exp 0", bus.rdata); end
        cyc();
        acc(CSR_RS, CSR_MSCRATCH, 32'h0000_00F0);
        vectors++; if (bus.rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL rs_old: got %h exp DEADBEEF", bus.rdata); end
        cyc();
        acc(CSR_RC, CSR_MSCRATCH, 32'h0000_000F);
        vectors++; if (bus.rdata !== 32'hDEAD_BEFF) begin miscompares++; $display("FAIL rs_result: got %h exp DEADBEFF", bus.rdata); end
        cyc();
        acc(CSR_RS, CSR_MSCRATCH, 32'h0);
        vectors++; if (bus.rdata !== 32'hDEAD_BEF0) begin miscompares++; $display("FAIL rc_result: got %h exp DEADBEF0", bus.rdata); end
        acc(CSR_RW, CSR_MTVEC, 32'h0000_2003);
        cyc();
        vectors++; if (trap_vector !== 32'h2000) begin miscompares++; $display("FAIL mtvec_warl: got %h exp 00002000", trap_vector); end
        acc(CSR_RW, CSR_MCAUSE, 32'hFFFF_FFFF);
        cyc();
        acc(CSR_RS, CSR_MCAUSE, 32'h0);
        vectors++; if (bus.rdata !== 32'h8000_000F) begin miscompares++; $display("FAIL mcause_warl: got %h exp 8000000F", bus.rdata); end
    endtask

    task automatic test_back_to_back();
        acc(CSR_RW, CSR_DSCRATCH, 32'h11);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL b2b_0: got %h exp 0", bus.rdata); end
        cyc();
        acc(CSR_RW, CSR_DSCRATCH, 32'h22);
        vectors++; if (bus.rdata !== 32'h11) begin miscompares++; $display("FAIL b2b_1: got %h exp 11", bus.rdata); end
        cyc();
        acc(CSR_RC, CSR_DSCRATCH, 32'h02);
        vectors++; if (bus.rdata !== 32'h22) begin miscompares++; $display("FAIL b2b_2: got %h exp 22", bus.rdata); end
        cyc();
        acc(CSR_RS, CSR_DSCRATCH, 32'h0);
        vectors++; if (bus.rdata !== 32'h20) begin miscompares++; $display("FAIL b2b_3: got %h exp 20", bus.rdata); end
    endtask

    task automatic test_counters();
        acc(CSR_RW, CSR_MCYCLE, 32'hFFFF_FFFE);
        cyc();
        acc(CSR_RS, CSR_MCYCLE, 32'h0);
        vectors++; if (bus.rdata !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL mcycle_wr_noinc: got %h exp FFFFFFFE", bus.rdata); end
        acc(CSR_RS, CSR_MCYCLEH, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mcycleh_pre: got %h exp 0", bus.rdata); end
        cyc();
        cyc();
        vectors++; if (bus.rdata !== 32'h1) begin miscompares++; $display("FAIL mcycleh_carry: got %h exp 1", bus.rdata); end
        acc(CSR_RS, CSR_MCYCLE, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL mcycle_wrap: got %h exp 0", bus.rdata); end
        acc(CSR_RW, CSR_MINSTRET, 32'h5);
        retire = 1'b1;
        cyc();
        acc(CSR_RS, CSR_MINSTRET, 32'h0);
        vectors++; if (bus.rdata !== 32'h5) begin miscompares++; $display("FAIL minstret_wr_noinc: got %h exp 5", bus.rdata); end
        cyc();
        cyc();
        retire = 1'b0;
        #1;
        vectors++; if (bus.rdata !== 32'h7) begin miscompares++; $display("FAIL minstret_retire: got %h exp 7", bus.rdata); end
    endtask

    task automatic test_timer();
        acc(CSR_RW, CSR_MCYCLEH, 32'h0);
        cyc();
        acc(CSR_RW, CSR_MCYCLE, 32'd100);
        cyc();
        acc(CSR_RW, CSR_MTIMECMPH, 32'h0);
        cyc();
        acc(CSR_RW, CSR_MTIMECMP, 32'd107);
        cyc();
        acc(CSR_RW, CSR_MIE, 32'h80);
        cyc();
        acc(CSR_RW, CSR_MSTATUS, 32'h8);
        cyc();
        acc(CSR_NONE, 12'h0, 32'h0);
        for (int unsigned c = 104; c <= 109; c++) begin
            vectors++; if (irq_pending !== (c >= 107)) begin miscompares++; $display("FAIL timer_irq c=%0d: got %b exp %b", c, irq_pending, (c >= 107)); end
            cyc();
        end
        irq_ext = 1'b1;
        irq_sw  = 1'b1;
        acc(CSR_RS, CSR_MIP, 32'h0);
        vectors++; if (bus.rdata !== 32'h888) begin miscompares++; $display("FAIL mip_read: got %h exp 888", bus.rdata); end
        irq_ext = 1'b0;
        irq_sw  = 1'b0;
        acc(CSR_RS, CSR_MSTATUS, 32'h0);
        vectors++; if (bus.rdata !== 32'h1808) begin miscompares++; $display("FAIL mstatus_mie: got %h exp 1808", bus.rdata); end
    endtask

    task automatic test_trap_mret();
        trap       = 1'b1;
        trap_cause = 32'd2;
        trap_pc    = 32'h1003;
        trap_tval  = 32'hBAD0_0001;
        retire     = 1'b1;
        acc(CSR_RW, CSR_MSCRATCH, 32'h1234_5678);
        cyc();
        trap   = 1'b0;
        retire = 1'b0;
        acc(CSR_RS, CSR_MSTATUS, 32'h0);
        vectors++; if (epc !== 32'h1000) begin miscompares++; $display("FAIL trap_epc: got %h exp 1000", epc); end
        vectors++; if (bus.rdata !== 32'h1880) begin miscompares++; $display("FAIL trap_mstatus: got %h exp 1880", bus.rdata); end
        vectors++; if (irq_pending !== 1'b0) begin miscompares++; $display("FAIL trap_irq_masked: got %b exp 0", irq_pending); end
        acc(CSR_RS, CSR_MSCRATCH, 32'h0);
        vectors++; if (bus.rdata !== 32'hDEAD_BEF0) begin miscompares++; $display("FAIL trap_drops_write: got %h exp DEADBEF0", bus.rdata); end
        acc(CSR_RS, CSR_MCAUSE, 32'h0);
        vectors++; if (bus.rdata !== 32'h2) begin miscompares++; $display("FAIL trap_mcause: got %h exp 2", bus.rdata); end
        acc(CSR_RS, CSR_MBADADDR, 32'h0);
        vectors++; if (bus.rdata !== 32'hBAD0_0001) begin miscompares++; $display("FAIL trap_mbadaddr: got %h exp BAD00001", bus.rdata); end
        acc(CSR_RS, CSR_MINSTRET, 32'h0);
        vectors++; if (bus.rdata !== 32'h8) begin miscompares++; $display("FAIL trap_retire_counts: got %h exp 8", bus.rdata); end
        mret = 1'b1;
        acc(CSR_RW, CSR_MSTATUS, 32'h0);
        cyc();
        mret = 1'b0;
        acc(CSR_RS, CSR_MSTATUS, 32'h0);
        vectors++; if (bus.rdata !== 32'h1888) begin miscompares++; $display("FAIL mret_mstatus: got %h exp 1888", bus.rdata); end
        vectors++; if (irq_pending !== 1'b1) begin miscompares++; $display("FAIL mret_irq: got %b exp 1", irq_pending); end
    endtask

    task automatic test_illegal();
        acc(CSR_RW, CSR_MCYCLE, 32'd1000);
        cyc();
        acc(CSR_RW, CSR_CYCLE, 32'h55);
        vectors++; if (bus.illegal !== 1'b1) begin miscompares++; $display("FAIL ro_write_illegal: got %b exp 1", bus.illegal); end
        cyc();
        acc(CSR_RS, CSR_CYCLE, 32'h0);
        vectors++; if (bus.illegal !== 1'b0) begin miscompares++; $display("FAIL ro_read_legal: got %b exp 0", bus.illegal); end
        vectors++; if (bus.rdata !== 32'd1001) begin miscompares++; $display("FAIL ro_no_change: got %0d exp 1001", bus.rdata); end
        acc(CSR_RW, 12'h7FF, 32'h5);
        vectors++; if (bus.illegal !== 1'b1) begin miscompares++; $display("FAIL unknown_illegal: got %b exp 1", bus.illegal); end
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL unknown_rdata: got %h exp 0", bus.rdata); end
        acc(CSR_RC, CSR_MHARTID, 32'h1);
        vectors++; if (bus.illegal !== 1'b1) begin miscompares++; $display("FAIL hartid_rc_illegal: got %b exp 1", bus.illegal); end
        acc(CSR_RS, CSR_MISA, 32'h0);
        vectors++; if (bus.rdata !== 32'h4000_0100) begin miscompares++; $display("FAIL misa: got %h exp 40000100", bus.rdata); end
        acc(CSR_RS, CSR_MHARTID, 32'h0);
        vectors++; if (bus.rdata !== 32'h0 || bus.illegal !== 1'b0) begin miscompares++; $display("FAIL hartid_read: got %h/%b exp 0/0", bus.rdata, bus.illegal); end
        acc(CSR_NONE, 12'h7FF, 32'h5);
        vectors++; if (bus.illegal !== 1'b0) begin miscompares++; $display("FAIL none_not_illegal: got %b exp 0", bus.illegal); end
    endtask

    task automatic test_reset_midop();
        acc(CSR_RW, CSR_MSCRATCH, 32'h0000_CAFE);
        rst_n = 1'b0;
        cyc();
        acc(CSR_RS, CSR_MSCRATCH, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL midreset_mscratch: got %h exp 0", bus.rdata); end
        vectors++; if (trap_vector !== 32'h100) begin miscompares++; $display("FAIL midreset_trap_vector: got %h exp 100", trap_vector); end
        vectors++; if (epc !== 32'h0 || irq_pending !== 1'b0) begin miscompares++; $display("FAIL midreset_epc_irq: got %h/%b exp 0/0", epc, irq_pending); end
        acc(CSR_RS, CSR_MSTATUS, 32'h0);
        vectors++; if (bus.rdata !== 32'h1800) begin miscompares++; $display("FAIL midreset_mstatus: got %h exp 1800", bus.rdata); end
        rst_n = 1'b1;
        acc(CSR_RS, CSR_MCYCLE, 32'h0);
        vectors++; if (bus.rdata !== 32'h0) begin miscompares++; $display("FAIL midreset_mcycle: got %h exp 0", bus.rdata); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        retire     = 1'b0;
        trap       = 1'b0;
        mret       = 1'b0;
        irq_ext    = 1'b0;
        irq_sw     = 1'b0;
        trap_cause = '0;
        trap_pc    = '0;
        trap_tval  = '0;
        bus.op     = CSR_NONE;
        bus.addr   = '0;
        bus.wdata  = '0;
        cyc();
        cyc();
        test_reset();
        test_rmw();
        test_back_to_back();
        test_counters();
        test_timer();
        test_trap_mret();
        test_illegal();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
